// File: rtl/lzrw1_pkg.sv
// lzrw1_pkg: types and default sizes shared by the LZRW1 decompressor blocks
// (history_copy_controller and history_buffer).
package lzrw1_pkg;

    localparam int HIST_SIZE_DEF   = 4096;
    localparam int ENTRY_WIDTH_DEF = 8;
    localparam int LEN_WIDTH_DEF   = 5;
    localparam int ADDR_W_DEF      = $clog2(HIST_SIZE_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LIT  = 2'd1,
        COPY = 2'd2
    } hcc_state_t;

    // Decoded item as produced by the item decoder (default-sized fields).
    typedef struct packed {
        logic                       is_copy;
        logic [ENTRY_WIDTH_DEF-1:0] literal;
        logic [ADDR_W_DEF-1:0]      offset;
        logic [LEN_WIDTH_DEF-1:0]   len;
    } item_t;

endpackage

// File: rtl/history_copy_controller.sv
// history_copy_controller: sequences the LZRW1 history buffer. Takes literal
// and copy items, emits the reconstructed stream at one byte per cycle and
// writes every emitted byte back into the history at wr_ptr.
// Ports:
//   clock, reset (sync, active high), clear (sync block restart, keeps err)
//   cmd_*   : item input, valid/ready handshake
//   out_*   : reconstructed byte stream, valid/ready handshake
//   hb_*    : history buffer write port and combinational read port
//   busy    : an item is being emitted
//   err     : sticky, set by an illegal copy or a copy reaching past the fill
module history_copy_controller
    import lzrw1_pkg::*;
#(
    parameter  int HISTORY_SIZE = HIST_SIZE_DEF,
    parameter  int ENTRY_WIDTH  = ENTRY_WIDTH_DEF,
    parameter  int LEN_WIDTH    = LEN_WIDTH_DEF,
    localparam int ADDR_W       = $clog2(HISTORY_SIZE)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_is_copy,
    input  logic [ENTRY_WIDTH-1:0] cmd_literal,
    input  logic [ADDR_W-1:0]      cmd_offset,
    input  logic [LEN_WIDTH-1:0]   cmd_len,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ENTRY_WIDTH-1:0] out_data,
    output logic                   hb_wr_en,
    output logic [ADDR_W-1:0]      hb_wr_addr,
    output logic [ENTRY_WIDTH-1:0] hb_data_in,
    output logic [ADDR_W-1:0]      hb_rd_addr,
    input  logic [ENTRY_WIDTH-1:0] hb_data_out,
    output logic                   busy,
    output logic                   err
);

    localparam logic [ADDR_W:0] FILL_MAX = (ADDR_W+1)'(HISTORY_SIZE);

    hcc_state_t             state_q, state_d;
    logic [ENTRY_WIDTH-1:0] lit_q, lit_d;
    logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [LEN_WIDTH-1:0]   rem_q, rem_d;
    logic [ADDR_W:0]        fill_q, fill_d;
    logic                   err_q, err_d;
    logic                   last, hs;

    always_comb begin
        state_d  = state_q;
        lit_d    = lit_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        rem_d    = rem_q;
        fill_d   = fill_q;
        err_d    = err_q;

        out_valid = (state_q != IDLE);
        last      = (state_q == LIT) || ((state_q == COPY) && (rem_q == LEN_WIDTH'(1)));
        hs        = out_valid && out_ready;
        // Accepting during the last handshake lets items run back to back.
        cmd_ready = (state_q == IDLE) || (hs && last);

        case (state_q)
            LIT:     out_data = lit_q;
            COPY:    out_data = hb_data_out;
            default: out_data = '0;
        endcase
        hb_rd_addr = (state_q == COPY) ? rd_ptr_q : wr_ptr_q;
        hb_wr_en   = hs;
        hb_wr_addr = wr_ptr_q;
        hb_data_in = out_data;
        busy       = out_valid;
        err        = err_q;

        if (hs) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (fill_q != FILL_MAX)
                fill_d = fill_q + 1'b1;
            if (state_q == COPY) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                rem_d    = rem_q - 1'b1;
            end
            if (last)
                state_d = IDLE;
        end

        // A new item sees the pointer/fill already advanced past the byte
        // handed off in this same cycle.
        if (cmd_valid && cmd_ready) begin
            if (!cmd_is_copy) begin
                lit_d   = cmd_literal;
                state_d = LIT;
            end else if (cmd_offset == '0 || cmd_len == '0) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                rd_ptr_d = wr_ptr_d - cmd_offset;
                rem_d    = cmd_len;
                state_d  = COPY;
                if ({1'b0, cmd_offset} > fill_d)
                    err_d = 1'b1;
            end
        end

        if (clear) begin
            state_d  = IDLE;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            rem_d    = '0;
            fill_d   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            lit_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            rem_q    <= '0;
            fill_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lit_q    <= lit_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rem_q    <= rem_d;
            fill_q   <= fill_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_history_copy_controller.sv
// Scoreboard bench for history_copy_controller with a 16-entry history.
module tb_history_copy_controller;

    localparam int HS = 16;
    localparam int AW = 4;
    localparam int EW = 8;
    localparam int LW = 5;

    logic          clock = 1'b0;
    logic          reset, clear, cmd_valid, cmd_is_copy, out_ready;
    logic [EW-1:0] cmd_literal;
    logic [AW-1:0] cmd_offset;
    logic [LW-1:0] cmd_len;
    logic          cmd_ready, out_valid, hb_wr_en, busy, err;
    logic [EW-1:0] out_data, hb_data_in, hb_data_out;
    logic [AW-1:0] hb_wr_addr, hb_rd_addr;

    always #5 clock = ~clock;

    history_copy_controller #(.HISTORY_SIZE(HS), .ENTRY_WIDTH(EW), .LEN_WIDTH(LW)) dut (
        .clock(clock), .reset(reset), .clear(clear),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_copy(cmd_is_copy),
        .cmd_literal(cmd_literal), .cmd_offset(cmd_offset), .cmd_len(cmd_len),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .hb_wr_en(hb_wr_en), .hb_wr_addr(hb_wr_addr), .hb_data_in(hb_data_in),
        .hb_rd_addr(hb_rd_addr), .hb_data_out(hb_data_out),
        .busy(busy), .err(err)
    );

    // History buffer stand-in: registered write, combinational read.
    logic [EW-1:0] mem [HS];
    always @(posedge clock) if (hb_wr_en) mem[hb_wr_addr] <= hb_data_in;
    assign hb_data_out = mem[hb_rd_addr];

    typedef struct {
        logic [EW-1:0] d;
        logic [AW-1:0] wa;
        logic [AW-1:0] ra;
        bit            chk_rd;
    } exp_t;

    exp_t          sb[$];
    logic [EW-1:0] m_hist [HS];
    logic [AW-1:0] m_wr;
    int            n_chk = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference decompression: expected bytes and addresses per item.
    task automatic model_item(input bit c, input logic [EW-1:0] lit,
                              input logic [AW-1:0] off, input logic [LW-1:0] len);
        logic [AW-1:0] a;
        if (!c) begin
            m_hist[m_wr] = lit;
            sb.push_back('{lit, m_wr, '0, 1'b0});
            m_wr = m_wr + 1'b1;
        end else if (off != 0 && len != 0) begin
            for (int i = 0; i < int'(len); i++) begin
                a = m_wr - off;
                m_hist[m_wr] = m_hist[a];
                sb.push_back('{m_hist[m_wr], m_wr, a, 1'b1});
                m_wr = m_wr + 1'b1;
            end
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (!reset && !clear && out_valid) begin
            chk("wr_en", hb_wr_en, out_ready);
            if (out_ready) begin
                if (sb.size() == 0) chk("sb_nonempty", sb.size(), 1);
                else begin
                    e = sb.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("wr_addr", hb_wr_addr, e.wa);
                    if (e.chk_rd) chk("rd_addr", hb_rd_addr, e.ra);
                end
            end
        end
    end

    task automatic send(input bit c, input logic [EW-1:0] lit, input logic [AW-1:0] off,
                        input logic [LW-1:0] len, output int waits);
        cmd_valid = 1'b1; cmd_is_copy = c; cmd_literal = lit; cmd_offset = off; cmd_len = len;
        waits = 0;
        @(negedge clock);
        while (!cmd_ready && waits < 200) begin
            waits++;
            @(negedge clock);
        end
        if (!cmd_ready) chk("accept_timeout", waits, 0);
        model_item(c, lit, off, len);
        @(posedge clock); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("drain_left", sb.size(), 0);
        @(posedge clock); #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
        sb.delete();
        m_wr = '0;
    endtask

    initial begin
        int w, wsum;
        for (int i = 0; i < HS; i++) begin mem[i] = '0; m_hist[i] = '0; end
        m_wr = '0;
        reset = 1'b1; clear = 1'b0; cmd_valid = 1'b0; cmd_is_copy = 1'b0;
        cmd_literal = '0; cmd_offset = '0; cmd_len = '0; out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_wr_en", hb_wr_en, 0);
        chk("rst_wr_addr", hb_wr_addr, 0);
        @(posedge clock); #1;

        // 1: back-to-back literals
        wsum = 0;
        send(0, 8'h41, 0, 0, w); wsum += w;
        send(0, 8'h42, 0, 0, w); wsum += w;
        send(0, 8'h43, 0, 0, w); wsum += w;
        chk("t1_ready_waits", wsum, 0);
        drain();

        // 2: run-length copy
        do_clear();
        send(0, 8'h61, 0, 0, w);
        send(1, 0, 4'd1, 5'd4, w);
        drain();

        // 3: overlapping copy with a two-cycle stall on the second byte
        do_clear();
        send(0, 8'h10, 0, 0, w);
        send(0, 8'h20, 0, 0, w);
        send(1, 0, 4'd2, 5'd3, w);
        @(negedge clock);
        @(posedge clock); #1 out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            chk("t3_stall_wr_en", hb_wr_en, 0);
            chk("t3_hold_data", out_data, 8'h20);
            chk("t3_hold_rd", hb_rd_addr, 1);
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        drain();

        // 4: pointer wrap in a 16-entry history
        do_clear();
        for (int i = 0; i < 14; i++) send(0, 8'(i), 0, 0, w);
        send(1, 0, 4'd3, 5'd4, w);
        drain();

        // 5: illegal items, then copy beyond fill after clear
        do_clear();
        send(1, 0, 4'd0, 5'd3, w);
        @(negedge clock);
        chk("t5_err", err, 1);
        chk("t5_no_out", out_valid, 0);
        @(posedge clock); #1;
        send(1, 0, 4'd1, 5'd0, w);
        send(0, 8'h77, 0, 0, w);
        drain();
        do_clear();
        chk("t5_err_kept", err, 1);
        send(0, 8'h01, 0, 0, w);
        send(0, 8'h02, 0, 0, w);
        send(1, 0, 4'd5, 5'd5, w);
        drain();
        chk("t5_err_still", err, 1);

        // 6: clear, then reset, in the middle of a copy
        do_clear();
        send(1, 0, 4'd3, 5'd10, w);
        repeat (3) begin @(posedge clock); #1; end
        do_clear();
        @(negedge clock);
        chk("t6_clr_busy", busy, 0);
        chk("t6_clr_out_valid", out_valid, 0);
        chk("t6_clr_wr_addr", hb_wr_addr, 0);
        chk("t6_clr_err", err, 1);
        @(posedge clock); #1;
        send(1, 0, 4'd3, 5'd10, w);
        repeat (3) begin @(posedge clock); #1; end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        sb.delete();
        m_wr = '0;
        @(negedge clock);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_wr_addr", hb_wr_addr, 0);
        chk("t6_rst_err", err, 0);
        chk("t6_rst_ready", cmd_ready, 1);
        @(posedge clock); #1;

        // copy reaching past the fill still runs and flags err
        send(0, 8'h5a, 0, 0, w);
        send(1, 0, 4'd2, 5'd2, w);
        drain();
        chk("t7_err", err, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
